// File: rtl/select_pkg.sv
// Shared types and default sizing for the select_int64 rank/select engine.
package select_pkg;

  localparam int SEL_WIDTH   = 64;
  localparam int SEL_CHUNK   = 8;
  localparam int NUM_CHUNKS  = SEL_WIDTH / SEL_CHUNK;
  localparam int CHUNK_IDX_W = $clog2(SEL_CHUNK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/select_chunk.sv
// Per-chunk popcount and in-chunk select: offset of the r-th set bit of one chunk.
module select_chunk #(
  parameter int CHUNK = 8,
  parameter int R_W   = 6,
  parameter int OFF_W = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0] chunk_bits,
  input  logic [R_W-1:0]   rank,
  output logic [R_W:0]     cnt,
  output logic             hit,
  output logic [OFF_W-1:0] offset
);

  logic [R_W:0] run_cnt;
  logic         seen;

  always_comb begin
    run_cnt = '0;
    seen    = 1'b0;
    offset  = '0;
    for (int j = 0; j < CHUNK; j++) begin
      if (chunk_bits[j]) begin
        // The first set bit reached with rank-many set bits below it is the answer.
        if (!seen && (run_cnt == {1'b0, rank})) begin
          offset = OFF_W'(j);
          seen   = 1'b1;
        end
        run_cnt = run_cnt + (R_W+1)'(1);
      end
    end
    cnt = run_cnt;
    hit = ({1'b0, rank} < run_cnt);
  end

endmodule

// File: rtl/select_int64.sv
// Sequential rank/select: position of the K-th set bit of a word, scanned
// CHUNK bits per cycle with early exit on the first chunk holding the hit.
//
// state | meaning
// IDLE  | ready for a request, no result pending
// SCAN  | examining chunk idx, rem = set bits still to skip
// DONE  | result held on out_pos/out_found until consumed
module select_int64
  import select_pkg::*;
#(
  parameter int WIDTH = SEL_WIDTH,
  parameter int CHUNK = SEL_CHUNK,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [IDX_W-1:0] in_rank,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_pos,
  output logic             out_found
);

  localparam int N_CHUNKS = WIDTH / CHUNK;
  localparam int CI_W     = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int OFF_W    = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0] rem_q, rem_d;
  logic [CI_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic             found_q, found_d;

  logic [CHUNK-1:0] chunk_bits;
  logic [IDX_W:0]   chunk_cnt;
  logic             chunk_hit;
  logic [OFF_W-1:0] chunk_off;

  assign chunk_bits = data_q[int'(idx_q)*CHUNK +: CHUNK];

  select_chunk #(
    .CHUNK (CHUNK),
    .R_W   (IDX_W),
    .OFF_W (OFF_W)
  ) u_chunk (
    .chunk_bits (chunk_bits),
    .rank       (rem_q),
    .cnt        (chunk_cnt),
    .hit        (chunk_hit),
    .offset     (chunk_off)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    found_d = found_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          rem_d   = in_rank;
          idx_d   = '0;
          pos_d   = '0;
          found_d = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (chunk_hit) begin
          pos_d   = IDX_W'(int'(idx_q) * CHUNK + int'(chunk_off));
          found_d = 1'b1;
          state_d = DONE;
        end else if (idx_q == CI_W'(N_CHUNKS - 1)) begin
          pos_d   = '0;
          found_d = 1'b0;
          state_d = DONE;
        end else begin
          // No hit means chunk_cnt <= rem, so this cannot wrap.
          rem_d = IDX_W'({1'b0, rem_q} - chunk_cnt);
          idx_d = idx_q + CI_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      found_q <= found_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_pos   = pos_q;
  assign out_found = found_q;

endmodule
